// File: rtl/irq_pkg.sv
// irq_pkg: shared types, defaults and helpers for the request-capture stage
package irq_pkg;
    localparam int N_REQ_DEFAULT = 4;
    typedef enum logic {IDLE, PRESENT} irq_state_e;
    function automatic int msb_index(input logic [15:0] vec);
        msb_index = 0;
        for (int i = 0; i < 16; i++)
            if (vec[i]) msb_index = i;
    endfunction
endpackage

// File: rtl/irq_edge_sync.sv
// irq_edge_sync: rising-edge detector on raw request lines
// IRQ_REQ_CAPTURE_SYNC_EN inserts a 2-flop synchronizer ahead of the detector
module irq_edge_sync #(
    parameter int N_REQ = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req_in,
    output logic [N_REQ-1:0] rise
);
    logic [N_REQ-1:0] src, req_prev;
`ifdef IRQ_REQ_CAPTURE_SYNC_EN
    logic [N_REQ-1:0] s1, s2;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            s1 <= '1;
            s2 <= '1;
        end else begin
            s1 <= req_in;
            s2 <= s1;
        end
    assign src = s2;
`else
    assign src = req_in;
`endif
    // all-ones at reset so lines already high at release are not events
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) req_prev <= '1;
        else req_prev <= src;
    assign rise = src & ~req_prev;
endmodule

// File: rtl/irq_req_capture.sv
// irq_req_capture: sticky edge-pending capture, masking and one-at-a-time presentation
// IRQ_REQ_CAPTURE_SYNC_EN adds a 2-flop input synchronizer (2 cycles extra latency)
module irq_req_capture import irq_pkg::*; #(
    parameter int N_REQ = N_REQ_DEFAULT,
    localparam int ID_W = $clog2(N_REQ)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req_in,
    input  logic [N_REQ-1:0] mask,
    output logic [N_REQ-1:0] pend_vec,
    output logic             irq_valid,
    output logic [ID_W-1:0]  irq_id,
    input  logic             irq_ack,
    output logic [N_REQ-1:0] ovf,
    input  logic [N_REQ-1:0] ovf_clr
);
    irq_state_e state;
    logic [N_REQ-1:0] pending, rise, clr;
    logic ack_fire;
    irq_edge_sync #(.N_REQ(N_REQ)) u_edge (.clk(clk), .rst_n(rst_n), .req_in(req_in), .rise(rise));
    assign ack_fire = irq_valid & irq_ack;
    assign clr = ack_fire ? N_REQ'(1) << irq_id : '0;
    assign pend_vec = pending & mask;
    assign irq_valid = state == PRESENT;
    // a rise on the line being acked re-pends it and is not an overrun
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            pending <= '0;
            ovf <= '0;
            state <= IDLE;
            irq_id <= '0;
        end else begin
            pending <= rise | (pending & ~clr);
            ovf <= (ovf & ~ovf_clr) | (rise & pending & ~clr);
            if (state == IDLE && |pend_vec) begin
                state <= PRESENT;
                irq_id <= ID_W'(msb_index(16'(pend_vec)));
            end else if (ack_fire) state <= IDLE;
        end
endmodule

// File: tb/tb_irq_req_capture.sv
// tb_irq_req_capture: directed and random checks against a per-line behavioural model
module tb_irq_req_capture;
    localparam int N = 4;
    logic clk = 0, rst_n = 0, irq_ack = 0, irq_valid;
    logic [N-1:0] req_in = '0, mask = '1, ovf_clr = '0, pend_vec, ovf;
    logic [1:0] irq_id;
    int total = 0, bad = 0;
    bit m_pend[N], m_ovf[N], m_prev[N], m_s1[N], m_s2[N], m_valid;
    int m_id;

    irq_req_capture #(.N_REQ(N)) dut (.clk(clk), .rst_n(rst_n), .req_in(req_in), .mask(mask),
        .pend_vec(pend_vec), .irq_valid(irq_valid), .irq_id(irq_id), .irq_ack(irq_ack),
        .ovf(ovf), .ovf_clr(ovf_clr));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_pend[i] = 0; m_ovf[i] = 0; m_prev[i] = 1; m_s1[i] = 1; m_s2[i] = 1;
        end
        m_valid = 0;
        m_id = 0;
    endtask

    // one clock of the reference, using the inputs held across this edge
    task automatic model_step();
        bit np[N], no[N], src[N], fire, acked, ev;
        int top;
        fire = m_valid && irq_ack;
        top = -1;
        for (int i = 0; i < N; i++) begin
`ifdef IRQ_REQ_CAPTURE_SYNC_EN
            src[i] = m_s2[i]; m_s2[i] = m_s1[i]; m_s1[i] = req_in[i];
`else
            src[i] = req_in[i];
`endif
            ev = src[i] && !m_prev[i];
            acked = fire && m_id == i;
            np[i] = ev ? 1'b1 : acked ? 1'b0 : m_pend[i];
            no[i] = (ev && m_pend[i] && !acked) ? 1'b1 : ovf_clr[i] ? 1'b0 : m_ovf[i];
            if (m_pend[i] && mask[i]) top = i;
            m_prev[i] = src[i];
        end
        if (m_valid) begin
            if (fire) m_valid = 0;
        end else if (top >= 0) begin
            m_valid = 1;
            m_id = top;
        end
        m_pend = np;
        m_ovf = no;
    endtask

    task automatic cmp_model();
        logic [N-1:0] ep, eo;
        for (int i = 0; i < N; i++) begin
            ep[i] = m_pend[i] && mask[i];
            eo[i] = m_ovf[i];
        end
        chk("pend_vec", 32'(pend_vec), 32'(ep));
        chk("irq_valid", 32'(irq_valid), 32'(m_valid));
        chk("irq_id", 32'(irq_id), 32'(m_id));
        chk("ovf", 32'(ovf), 32'(eo));
    endtask

    task automatic cyc();
        @(posedge clk);
        model_step();
        @(negedge clk);
        cmp_model();
    endtask

    initial begin
        model_reset();
        req_in = 4'b0100;
        #2;
        chk("rst_pend", 32'(pend_vec), 0);
        chk("rst_valid", 32'(irq_valid), 0);
        chk("rst_id", 32'(irq_id), 0);
        chk("rst_ovf", 32'(ovf), 0);
        @(negedge clk);
        rst_n = 1;
        repeat (10) cyc();
        chk("held_high_pend", 32'(pend_vec), 0);
        chk("held_high_valid", 32'(irq_valid), 0);
        // single event on line 1
        req_in = 0; cyc();
        req_in = 4'b0010; cyc();
        chk("ev1_pend", 32'(pend_vec), 4'b0010);
        chk("ev1_valid_early", 32'(irq_valid), 0);
        cyc();
        chk("ev1_valid", 32'(irq_valid), 1);
        chk("ev1_id", 32'(irq_id), 1);
        irq_ack = 1; cyc(); irq_ack = 0;
        chk("ev1_acked_pend", 32'(pend_vec), 0);
        chk("ev1_acked_valid", 32'(irq_valid), 0);
        // simultaneous lines 0 and 3: priority then one idle gap
        req_in = 0; cyc();
        req_in = 4'b1001; cyc(); cyc();
        chk("pri_first", 32'(irq_id), 3);
        irq_ack = 1; cyc(); irq_ack = 0;
        chk("pri_gap", 32'(irq_valid), 0);
        chk("pri_left", 32'(pend_vec), 4'b0001);
        cyc();
        chk("pri_second_valid", 32'(irq_valid), 1);
        chk("pri_second", 32'(irq_id), 0);
        irq_ack = 1; cyc(); irq_ack = 0;
        // mask removed while presenting: no retraction
        req_in = 0; cyc();
        req_in = 4'b0100; cyc(); cyc();
        mask = 4'b1011; cyc();
        chk("mask_hold_valid", 32'(irq_valid), 1);
        chk("mask_hold_id", 32'(irq_id), 2);
        irq_ack = 1; cyc(); irq_ack = 0;
        mask = '1; cyc();
        chk("mask_ack_pend", 32'(pend_vec), 0);
        chk("mask_ack_valid", 32'(irq_valid), 0);
        // overrun, clear, and re-event on the acked line
        req_in = 0; cyc();
        req_in = 4'b0100; cyc(); cyc();
        req_in = 0; cyc();
        req_in = 4'b0100; cyc();
        chk("ovf_set", 32'(ovf), 4'b0100);
        ovf_clr = 4'b0100; cyc(); ovf_clr = 0;
        chk("ovf_clr", 32'(ovf), 0);
        req_in = 0; cyc();
        req_in = 4'b0100; irq_ack = 1; cyc(); irq_ack = 0;
        chk("reack_pend", 32'(pend_vec), 4'b0100);
        chk("reack_ovf", 32'(ovf), 0);
        cyc();
        chk("reack_valid", 32'(irq_valid), 1);
        irq_ack = 1; cyc(); irq_ack = 0;
        // asynchronous reset mid-operation
        req_in = 0; cyc();
        req_in = 4'b1000; cyc(); cyc();
        #2 rst_n = 0;
        #1;
        chk("midrst_pend", 32'(pend_vec), 0);
        chk("midrst_valid", 32'(irq_valid), 0);
        chk("midrst_id", 32'(irq_id), 0);
        model_reset();
        @(negedge clk);
        rst_n = 1;
        cyc();
        // random traffic
        for (int k = 0; k < 3000; k++) begin
            req_in = req_in ^ (N'($urandom) & N'($urandom));
            mask = ($urandom_range(0, 3) == 0) ? N'($urandom) : '1;
            irq_ack = 1'($urandom);
            ovf_clr = ($urandom_range(0, 7) == 0) ? N'($urandom) : '0;
            cyc();
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
